// File: rtl/asteroid_dino_motion_if.sv
// Control inputs and timing/motion outputs of the asteroid/dino motion core.
// master drives the game controls, slave is the motion core.
interface asteroid_dino_motion_if;
  logic       restart;
  logic       halt;
  logic       asteroid_on;
  logic       pix_en;
  logic       clk_div;
  logic       sprite;
  logic       step;
  logic [9:0] xmovaddr;
  logic [9:0] ymovaddr;

  modport master (
    output restart, halt, asteroid_on,
    input  pix_en, clk_div, sprite, step, xmovaddr, ymovaddr
  );

  modport slave (
    input  restart, halt, asteroid_on,
    output pix_en, clk_div, sprite, step, xmovaddr, ymovaddr
  );
endinterface

// File: rtl/asteroid_dino_motion.sv
// Timing/motion core: pixel-rate divider, dino run-frame toggle and one
// asteroid's wrapping X/Y offsets. Every output comes straight from a flop.
module asteroid_dino_motion #(
  parameter int unsigned DIV           = 4,
  parameter int unsigned SPRITE_PERIOD = 2500000,
  parameter int unsigned MOVE_PERIOD   = 250000,
  parameter int unsigned X_STEP        = 1,
  parameter int unsigned Y_STEP        = 1,
  parameter int unsigned X_LIMIT       = 640,
  parameter int unsigned Y_LIMIT       = 380
) (
  input  logic                  clk,
  input  logic                  reset_n,
  asteroid_dino_motion_if.slave bus
);

  localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned SPR_W = (SPRITE_PERIOD > 1) ? $clog2(SPRITE_PERIOD) : 1;
  localparam int unsigned MOV_W = (MOVE_PERIOD > 1) ? $clog2(MOVE_PERIOD) : 1;
  localparam int unsigned POS_W = 10;
  localparam int unsigned SUM_W = POS_W + 1;

  logic [DIV_W-1:0] div_cnt, div_cnt_nxt;
  logic [SPR_W-1:0] spr_cnt, spr_cnt_nxt;
  logic [MOV_W-1:0] mov_cnt, mov_cnt_nxt;
  logic [POS_W-1:0] xpos, xpos_nxt;
  logic [POS_W-1:0] ypos, ypos_nxt;
  logic [SUM_W-1:0] x_sum, y_sum;
  logic             pix_en_q, pix_en_nxt;
  logic             clk_div_q, clk_div_nxt;
  logic             sprite_q, sprite_nxt;
  logic             step_q, step_nxt;

  // Next-state for divider, sprite toggle and asteroid motion
  always_comb begin
    div_cnt_nxt = div_cnt;
    spr_cnt_nxt = spr_cnt;
    mov_cnt_nxt = mov_cnt;
    xpos_nxt    = xpos;
    ypos_nxt    = ypos;
    sprite_nxt  = sprite_q;
    step_nxt    = 1'b0;
    pix_en_nxt  = 1'b0;
    clk_div_nxt = 1'b0;
    x_sum       = {1'b0, xpos} + SUM_W'(X_STEP);
    y_sum       = {1'b0, ypos} + SUM_W'(Y_STEP);

    if (div_cnt == DIV_W'(DIV - 1)) begin
      div_cnt_nxt = '0;
      pix_en_nxt  = 1'b1;
    end else begin
      div_cnt_nxt = div_cnt + 1'b1;
    end
    clk_div_nxt = (div_cnt >= DIV_W'(DIV / 2));

    if (pix_en_q) begin
      if (spr_cnt == SPR_W'(SPRITE_PERIOD - 1)) begin
        spr_cnt_nxt = '0;
        sprite_nxt  = ~sprite_q;
      end else begin
        spr_cnt_nxt = spr_cnt + 1'b1;
      end
    end

    // restart and asteroid_on both outrank halt; halt keeps the period phase
    if (bus.restart || !bus.asteroid_on) begin
      mov_cnt_nxt = '0;
      xpos_nxt    = '0;
      ypos_nxt    = '0;
    end else if (!bus.halt && pix_en_q) begin
      if (mov_cnt == MOV_W'(MOVE_PERIOD - 1)) begin
        mov_cnt_nxt = '0;
        step_nxt    = 1'b1;
        xpos_nxt    = (x_sum >= SUM_W'(X_LIMIT)) ? '0 : x_sum[POS_W-1:0];
        ypos_nxt    = (y_sum >= SUM_W'(Y_LIMIT)) ? '0 : y_sum[POS_W-1:0];
      end else begin
        mov_cnt_nxt = mov_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt   <= '0;
      spr_cnt   <= '0;
      mov_cnt   <= '0;
      xpos      <= '0;
      ypos      <= '0;
      pix_en_q  <= 1'b0;
      clk_div_q <= 1'b0;
      sprite_q  <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      div_cnt   <= div_cnt_nxt;
      spr_cnt   <= spr_cnt_nxt;
      mov_cnt   <= mov_cnt_nxt;
      xpos      <= xpos_nxt;
      ypos      <= ypos_nxt;
      pix_en_q  <= pix_en_nxt;
      clk_div_q <= clk_div_nxt;
      sprite_q  <= sprite_nxt;
      step_q    <= step_nxt;
    end
  end

  assign bus.pix_en   = pix_en_q;
  assign bus.clk_div  = clk_div_q;
  assign bus.sprite   = sprite_q;
  assign bus.step     = step_q;
  assign bus.xmovaddr = xpos;
  assign bus.ymovaddr = ypos;

endmodule

// File: tb/tb_asteroid_dino_motion.sv
// Bench for asteroid_dino_motion: directed scenarios plus random controls,
// checked every cycle against an edge-count based reference model.
module tb_asteroid_dino_motion;

  localparam int unsigned DIV = 4;
  localparam int unsigned SP  = 3;
  localparam int unsigned MP  = 2;
  localparam int unsigned XS  = 1;
  localparam int unsigned YS  = 1;
  localparam int unsigned XL  = 8;
  localparam int unsigned YL  = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  asteroid_dino_motion_if bus ();

  asteroid_dino_motion #(
    .DIV(DIV), .SPRITE_PERIOD(SP), .MOVE_PERIOD(MP),
    .X_STEP(XS), .Y_STEP(YS), .X_LIMIT(XL), .Y_LIMIT(YL)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, expressed as counts since reset release
  int unsigned e;
  int unsigned spr_pulses;
  int unsigned phase;
  int unsigned nsteps;
  int unsigned mx, my;
  bit m_pix, m_clkdiv, m_sprite, m_step;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    e = 0; spr_pulses = 0; phase = 0; nsteps = 0; mx = 0; my = 0;
    m_pix = 0; m_clkdiv = 0; m_sprite = 0; m_step = 0;
  endtask

  // Advance the model by one rising clk edge, using the inputs the DUT sees
  task automatic model_edge();
    bit old_pix;
    old_pix  = m_pix;
    e++;
    m_pix    = (e % DIV) == 0;
    m_clkdiv = ((e - 1) % DIV) >= (DIV / 2);
    if (old_pix) begin
      spr_pulses++;
      m_sprite = ((spr_pulses / SP) % 2) == 1;
    end
    m_step = 0;
    if (bus.restart || !bus.asteroid_on) begin
      phase = 0; mx = 0; my = 0;
    end else if (!bus.halt && old_pix) begin
      phase++;
      if (phase == MP) begin
        phase  = 0;
        m_step = 1;
        nsteps++;
        mx = (mx + XS >= XL) ? 0 : mx + XS;
        my = (my + YS >= YL) ? 0 : my + YS;
      end
    end
  endtask

  task automatic check_all();
    check_val("pix_en",   32'(bus.pix_en),   32'(m_pix));
    check_val("clk_div",  32'(bus.clk_div),  32'(m_clkdiv));
    check_val("sprite",   32'(bus.sprite),   32'(m_sprite));
    check_val("step",     32'(bus.step),     32'(m_step));
    check_val("xmovaddr", 32'(bus.xmovaddr), mx);
    check_val("ymovaddr", 32'(bus.ymovaddr), my);
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Count pix_en pulses seen until step rises; includes the currently sampled pix_en
  task automatic pix_until_step(output int cnt);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.pix_en) cnt++;
      run_cycle();
      if (bus.step) break;
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check_val({tag, "_pix"},  32'(bus.pix_en),   0);
    check_val({tag, "_cdiv"}, 32'(bus.clk_div),  0);
    check_val({tag, "_spr"},  32'(bus.sprite),   0);
    check_val({tag, "_step"}, 32'(bus.step),     0);
    check_val({tag, "_x"},    32'(bus.xmovaddr), 0);
    check_val({tag, "_y"},    32'(bus.ymovaddr), 0);
  endtask

  initial begin
    int n;
    bus.restart = 0; bus.halt = 0; bus.asteroid_on = 0;
    model_reset();
    #1 reset_n = 0;
    #1 check_zero_outputs("por");
    @(negedge clk);
    reset_n = 1;
    model_reset();
    check_all();

    // First pix_en after the 4th edge
    bus.asteroid_on = 1;
    for (int i = 0; i < 3; i++) run_cycle();
    check_val("pix_before_4th", 32'(bus.pix_en), 0);
    run_cycle();
    check_val("pix_first", 32'(bus.pix_en), 1);

    // Wrap behaviour after 5 and 8 steps
    n = 0;
    while (nsteps < 5 && n < 2000) begin run_cycle(); n++; end
    check_val("x_after5", 32'(bus.xmovaddr), 5);
    check_val("y_after5", 32'(bus.ymovaddr), 0);
    n = 0;
    while (nsteps < 8 && n < 2000) begin run_cycle(); n++; end
    check_val("x_after8", 32'(bus.xmovaddr), 0);
    check_val("y_after8", 32'(bus.ymovaddr), 3);

    // Halt one pix_en into a period, resume needs exactly one more pix_en
    n = 0;
    while (!(phase == 1 && !m_pix) && n < 200) begin run_cycle(); n++; end
    bus.halt = 1;
    for (int i = 0; i < 10 * DIV; i++) run_cycle();
    check_val("halt_x_frozen", 32'(bus.xmovaddr), 0);
    check_val("halt_y_frozen", 32'(bus.ymovaddr), 3);
    bus.halt = 0;
    pix_until_step(n);
    check_val("halt_resume_pix", n, 1);

    // restart together with halt at x=6, y=2
    n = 0;
    while (!(mx == 6 && my == 2) && n < 3000) begin run_cycle(); n++; end
    check_val("pre_restart_x", 32'(bus.xmovaddr), 6);
    check_val("pre_restart_y", 32'(bus.ymovaddr), 2);
    while (m_pix) run_cycle();
    bus.restart = 1; bus.halt = 1;
    run_cycle();
    check_val("restart_x", 32'(bus.xmovaddr), 0);
    check_val("restart_y", 32'(bus.ymovaddr), 0);
    bus.restart = 0; bus.halt = 0;
    pix_until_step(n);
    check_val("restart_first_step_pix", n, 2);

    // asteroid_on=0 at x=4 clears and holds
    n = 0;
    while (mx != 4 && n < 2000) begin run_cycle(); n++; end
    while (m_pix) run_cycle();
    bus.asteroid_on = 0;
    run_cycle();
    check_val("off_x", 32'(bus.xmovaddr), 0);
    check_val("off_y", 32'(bus.ymovaddr), 0);
    for (int i = 0; i < 30; i++) run_cycle();
    check_val("off_hold_x", 32'(bus.xmovaddr), 0);
    bus.asteroid_on = 1;
    pix_until_step(n);
    check_val("reenable_first_step_pix", n, 2);

    // Random control traffic
    for (int i = 0; i < 3000; i++) begin
      bus.restart = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 19) == 0) bus.halt = ~bus.halt;
      if ($urandom_range(0, 29) == 0) bus.asteroid_on = ~bus.asteroid_on;
      run_cycle();
    end
    bus.restart = 0; bus.halt = 0; bus.asteroid_on = 1;
    for (int i = 0; i < 60; i++) run_cycle();

    // Asynchronous reset between clock edges
    #2 reset_n = 0;
    #1 check_zero_outputs("async_rst");
    #1 reset_n = 1;
    model_reset();
    for (int i = 0; i < 3; i++) run_cycle();
    check_val("rst_pix_before_4th", 32'(bus.pix_en), 0);
    run_cycle();
    check_val("rst_pix_first", 32'(bus.pix_en), 1);
    for (int i = 0; i < 80; i++) run_cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
